// File: rtl/pulse_rate_meter_if.sv
// Result port of pulse_rate_meter: one count word plus overflow flag under valid/ready.
// A transfer happens on a rising clock edge where count_valid and count_ready are both 1;
// the producer holds count/overflow stable while count_valid=1 and count_ready=0.
interface pulse_rate_meter_if #(
  parameter int WORD_WIDTH = 8
);
  logic                  count_valid;
  logic                  count_ready;
  logic [WORD_WIDTH-1:0] count;
  logic                  overflow;

  modport master (
    output count_valid,
    output count,
    output overflow,
    input  count_ready
  );

  modport slave (
    input  count_valid,
    input  count,
    input  overflow,
    output count_ready
  );
endinterface

// File: rtl/pulse_rate_meter.sv
// Counts pulses_in high cycles between window_tick pulses and reports each window.
// Define PULSE_RATE_METER_SATURATE_EN to saturate the accumulator instead of wrapping.
module pulse_rate_meter #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                clock,
  input  logic                clear_n,
  input  logic                window_tick,
  input  logic                pulses_in,
  pulse_rate_meter_if.master  cnt,
  output logic                dropped,
  output logic                state_dbg
);

  typedef enum logic {
    ARM     = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] acc;
  logic                  acc_ovf;
  logic                  valid_q;
  logic [WORD_WIDTH-1:0] count_q;
  logic                  overflow_q;

  logic [WORD_WIDTH:0]   sum;
  logic                  carry;
  logic [WORD_WIDTH-1:0] acc_next;
  logic                  ovf_next;
  logic                  transfer;

  always_comb begin
    sum      = {1'b0, acc} + {{WORD_WIDTH{1'b0}}, pulses_in};
    carry    = sum[WORD_WIDTH];
`ifdef PULSE_RATE_METER_SATURATE_EN
    // A carry can only come from an all-ones accumulator, so holding acc pins it there.
    acc_next = carry ? acc : sum[WORD_WIDTH-1:0];
`else
    acc_next = sum[WORD_WIDTH-1:0];
`endif
    ovf_next = acc_ovf | carry;
    transfer = valid_q & cnt.count_ready;
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state      <= ARM;
      acc        <= '0;
      acc_ovf    <= 1'b0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      dropped <= 1'b0;
      if (transfer) valid_q <= 1'b0;

      case (state)
        ARM: begin
          if (window_tick) state <= MEASURE;
        end
        MEASURE: begin
          if (window_tick) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
            // Load when empty or when the held entry leaves this same cycle.
            if (!valid_q || cnt.count_ready) begin
              valid_q    <= 1'b1;
              count_q    <= acc_next;
              overflow_q <= ovf_next;
            end else begin
              dropped <= 1'b1;
            end
          end else begin
            acc     <= acc_next;
            acc_ovf <= ovf_next;
          end
        end
        default: state <= ARM;
      endcase
    end
  end

  assign cnt.count_valid = valid_q;
  assign cnt.count       = count_q;
  assign cnt.overflow    = overflow_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Directed bench for pulse_rate_meter with WORD_WIDTH=4 and hand-computed results.
module tb_pulse_rate_meter;

  localparam int W = 4;

  logic clock;
  logic clear_n;
  logic window_tick;
  logic pulses_in;
  logic dropped;
  logic state_dbg;

  pulse_rate_meter_if #(.WORD_WIDTH(W)) cnt_if ();

  pulse_rate_meter #(.WORD_WIDTH(W)) dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .window_tick (window_tick),
    .pulses_in   (pulses_in),
    .cnt         (cnt_if.master),
    .dropped     (dropped),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle with the given inputs; outputs are sampled 1ns after the edge.
  task automatic step(input logic tick, input logic pulse, input logic ready);
    window_tick        = tick;
    pulses_in          = pulse;
    cnt_if.count_ready = ready;
    @(posedge clock);
    #1;
  endtask

  task automatic check_result(input string tag, input logic ovf);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    check({tag, "_valid"}, {31'd0, cnt_if.count_valid}, 32'd1);
    check({tag, "_count"}, {28'd0, cnt_if.count}, {28'd0, e});
    check({tag, "_ovf"},   {31'd0, cnt_if.overflow}, {31'd0, ovf});
  endtask

  initial begin
    clear_n            = 1'b0;
    window_tick        = 1'b0;
    pulses_in          = 1'b0;
    cnt_if.count_ready = 1'b0;

    // Reset, with a coincident tick that reset must override.
    step(1'b1, 1'b1, 1'b1);
    check("rst_valid",   {31'd0, cnt_if.count_valid}, 32'd0);
    check("rst_count",   {28'd0, cnt_if.count}, 32'd0);
    check("rst_ovf",     {31'd0, cnt_if.overflow}, 32'd0);
    check("rst_dropped", {31'd0, dropped}, 32'd0);
    check("rst_state",   {31'd0, state_dbg}, 32'd0);
    clear_n = 1'b1;

    // Arming: events before the first tick are ignored.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b1);
      check("arm_valid",   {31'd0, cnt_if.count_valid}, 32'd0);
      check("arm_dropped", {31'd0, dropped}, 32'd0);
    end
    step(1'b1, 1'b0, 1'b1);
    check("arm_tick_state",   {31'd0, state_dbg}, 32'd1);
    check("arm_tick_valid",   {31'd0, cnt_if.count_valid}, 32'd0);
    check("arm_tick_dropped", {31'd0, dropped}, 32'd0);

    // Basic: three separated events.
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    exp_q.push_back(4'd3);
    step(1'b1, 1'b0, 1'b1);
    check_result("basic", 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("basic_one_cycle", {31'd0, cnt_if.count_valid}, 32'd0);

    // Coincident event belongs to the closing window: 2 + 1, then 4.
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    exp_q.push_back(4'd3);
    step(1'b1, 1'b1, 1'b1);
    check_result("coinc1", 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
    exp_q.push_back(4'd4);
    step(1'b1, 1'b0, 1'b1);
    check_result("coinc2", 1'b0);
    step(1'b0, 1'b0, 1'b1);

    // Overflow: 20 events in a 4-bit window.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1);
`ifdef PULSE_RATE_METER_SATURATE_EN
    exp_q.push_back(4'd15);
`else
    exp_q.push_back(4'd4);
`endif
    step(1'b1, 1'b0, 1'b1);
    check_result("ovf", 1'b1);
    // Window after overflow must start clean; tick-cycle event only.
    exp_q.push_back(4'd1);
    step(1'b1, 1'b1, 1'b1);
    check_result("post_ovf", 1'b0);
    // Window length 1 with no event; transfer and load in the same cycle.
    exp_q.push_back(4'd0);
    step(1'b1, 1'b0, 1'b1);
    check_result("len1", 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("len1_drain", {31'd0, cnt_if.count_valid}, 32'd0);

    // Backpressure: 2 held, 5 dropped.
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    exp_q.push_back(4'd2);
    step(1'b1, 1'b0, 1'b0);
    check_result("bp_first", 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0);
      check("bp_hold_count", {28'd0, cnt_if.count}, 32'd2);
      check("bp_hold_valid", {31'd0, cnt_if.count_valid}, 32'd1);
    end
    step(1'b1, 1'b0, 1'b0);
    check("bp_dropped",    {31'd0, dropped}, 32'd1);
    check("bp_drop_count", {28'd0, cnt_if.count}, 32'd2);
    step(1'b0, 1'b0, 1'b0);
    check("bp_dropped_once", {31'd0, dropped}, 32'd0);
    check("bp_still_count",  {28'd0, cnt_if.count}, 32'd2);
    step(1'b0, 1'b0, 1'b1);
    check("bp_xfer_valid", {31'd0, cnt_if.count_valid}, 32'd0);

    // Reset mid-operation with data pending and accumulator at 6.
    step(1'b1, 1'b0, 1'b0);
    check("mid_pending", {31'd0, cnt_if.count_valid}, 32'd1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    clear_n = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    clear_n = 1'b1;
    check("mid_rst_valid",   {31'd0, cnt_if.count_valid}, 32'd0);
    check("mid_rst_count",   {28'd0, cnt_if.count}, 32'd0);
    check("mid_rst_ovf",     {31'd0, cnt_if.overflow}, 32'd0);
    check("mid_rst_dropped", {31'd0, dropped}, 32'd0);
    check("mid_rst_state",   {31'd0, state_dbg}, 32'd0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("rearm_valid", {31'd0, cnt_if.count_valid}, 32'd0);
    check("rearm_state", {31'd0, state_dbg}, 32'd1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    exp_q.push_back(4'd2);
    step(1'b1, 1'b0, 1'b1);
    check_result("rearm_win", 1'b0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
